// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// An accepted start with a non-zero divisor gives done exactly N_W cycles later.
// A zero divisor completes one cycle after acceptance with the saturated result.
// Q, R and div_by_zero are registered and change only on completion or reset.
//
// Handshake: start is accepted on a rising edge only while busy is low (IDLE or FIN).
// Y and B are captured on that edge, and start seen while busy is high is ignored.
// done is a one-cycle pulse while in FIN, and Q/R/div_by_zero are valid from that
// cycle until the next completion.
module restoring_divider #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] Y,
  input  logic [D_W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           div_by_zero,
  output logic [1:0]     dbg_state
);

  localparam int C_W = $clog2(N_W) + 1;
  localparam logic [C_W-1:0] CNT_INIT = C_W'(N_W);
  localparam logic [C_W-1:0] CNT_ONE  = C_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  // Partial remainder, one bit wider than the divisor so the shifted value
  // never loses its top bit before the trial subtraction.
  logic [D_W:0]   rem_q, rem_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  // After N_W steps this register holds the quotient.
  logic [N_W-1:0] dvd_q, dvd_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  logic           zero_q, zero_d;
  logic [N_W-1:0] q_q, q_d;
  logic [D_W-1:0] r_q, r_d;
  logic           dbz_q, dbz_d;

  // Datapath for one restoring step
  logic [D_W+1:0] shifted_w;
  logic [D_W+1:0] diff_w;
  logic           fits_w;
  logic [D_W:0]   rem_step;
  logic [N_W-1:0] dvd_step;

  // One restoring step: shift, trial-subtract, keep the difference or restore.
  // The partial remainder is always < divisor, so the shifted value stays below
  // 2*divisor. Bit D_W+1 of the difference is therefore a pure borrow flag.
  always_comb begin
    shifted_w = {rem_q, dvd_q[N_W-1]};
    diff_w    = shifted_w - {2'b00, dvs_q};
    fits_w    = ~diff_w[D_W+1];
    rem_step  = fits_w ? diff_w[D_W:0] : shifted_w[D_W:0];
    dvd_step  = {dvd_q[N_W-2:0], fits_w};
  end

  // Next-state and register-update logic for the IDLE/CALC/FIN controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          // Accept: capture operands and reset the iteration.
          // A zero divisor still passes through CALC for one cycle so that busy
          // is high for exactly that cycle. No restoring step is done then.
          state_d = CALC;
          dvd_d   = Y;
          dvs_d   = B;
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          zero_d  = (B == '0);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (zero_q) begin
          state_d = FIN;
          q_d     = '1;
          r_d     = '0;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = FIN;
            q_d     = dvd_step;
            r_d     = rem_step[D_W-1:0];
            dbz_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status outputs are decoded straight from the state register
  always_comb begin
    busy        = (state_q == CALC);
    done        = (state_q == FIN);
    Q           = q_q;
    R           = r_q;
    div_by_zero = dbz_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider.
// The driver pushes the expected result and the expected done cycle.
// A negedge monitor pops and checks each done pulse, and also checks that
// Q/R/div_by_zero hold between completions.
module tb_restoring_divider;

  localparam int N_W = 16;
  localparam int D_W = 8;
  localparam int E_W = 32 + D_W + N_W + 1 + D_W + N_W;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N_W-1:0] Y;
  logic [D_W-1:0] B;
  logic           busy;
  logic           done;
  logic [N_W-1:0] Q;
  logic [D_W-1:0] R;
  logic           div_by_zero;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = '0;

  // Entry layout: {done_cycle, b, y, dbz, r, q}
  logic [E_W-1:0] exp_q[$];

  logic [N_W-1:0] last_q;
  logic [D_W-1:0] last_r;
  logic           last_z;

  restoring_divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Y(Y), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // Clock and posedge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one operation at the current negedge and push its expected result.
  // The done pulse is visible at the negedge when cyc == now + 1 + latency.
  task automatic drive(input logic [N_W-1:0] y, input logic [D_W-1:0] b,
                       input logic [N_W-1:0] q, input logic [D_W-1:0] r, input logic z);
    logic [31:0] due;
    due   = cyc + 32'd1 + (z ? 32'd1 : 32'(N_W));
    start = 1'b1;
    Y     = y;
    B     = b;
    exp_q.push_back({due, b, y, z, r, q});
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_waiting_done", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout_b2b_done", 64'(done), 64'd1);
  endtask

  // Monitor: check each done pulse against the scoreboard, and check that the
  // outputs hold while no done is shown.
  always @(negedge clk) begin
    logic [E_W-1:0] e;
    logic [31:0]    e_cyc;
    logic [D_W-1:0] e_b, e_r;
    logic [N_W-1:0] e_y, e_q;
    logic           e_z;
    if (!rst_n) begin
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        {e_cyc, e_b, e_y, e_z, e_r, e_q} = e;
        check("q", 64'(Q), 64'(e_q));
        check("r", 64'(R), 64'(e_r));
        check("div_by_zero", 64'(div_by_zero), 64'(e_z));
        check("done_cycle", 64'(cyc), 64'(e_cyc));
        check("busy_at_done", 64'(busy), 64'd0);
        if (!e_z) begin
          check("identity", 64'(32'(Q) * 32'(e_b) + 32'(R)), 64'(e_y));
          check("r_lt_b", 64'(R < e_b), 64'd1);
        end
      end
      last_q = Q;
      last_r = R;
      last_z = div_by_zero;
    end else begin
      check("hold_outputs", 64'({Q, R, div_by_zero}), 64'({last_q, last_r, last_z}));
    end
  end

  // Directed vectors: {y, b, q, r, dbz}
  logic [N_W-1:0] tv_y[8] = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd5, 16'd0, 16'd255, 16'd12345, 16'd65534};
  logic [D_W-1:0] tv_b[8] = '{8'hFF, 8'd1, 8'd200, 8'd0, 8'd9, 8'd16, 8'd255, 8'd2};
  logic [N_W-1:0] tv_q[8] = '{16'h0101, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0, 16'd15, 16'd48, 16'd32767};
  logic [D_W-1:0] tv_r[8] = '{8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd15, 8'd105, 8'd0};
  logic           tv_z[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [N_W-1:0] ry;
    logic [D_W-1:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    Y     = '0;
    B     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(Q), 64'd0);
    check("rst_r", 64'(R), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // First edge after reset release accepts: 1000 / 7 = 142 r 6
    rst_n = 1'b1;
    drive(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < N_W; i++) begin
      @(negedge clk);
      check("busy_during_calc", 64'(busy), 64'd1);
      check("no_early_done", 64'(done), 64'd0);
    end
    wait_empty();

    // Directed table, busy checked on the cycle after acceptance
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(tv_y[k], tv_b[k], tv_q[k], tv_r[k], tv_z[k]);
      @(posedge clk);
      #1 start = 1'b0;
      Y = '1;
      B = '1;
      @(negedge clk);
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_empty();
    end

    // Start during CALC is ignored: 50000 / 123 = 406 r 62
    @(negedge clk);
    drive(16'd50000, 8'd123, 16'd406, 8'd62, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    Y = 16'd9;
    B = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty();

    // Reset at edge 8 abandons the division
    @(negedge clk);
    drive(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_q", 64'(Q), 64'd0);
    check("mid_rst_r", 64'(R), 64'd0);
    check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(16'd100, 8'd10, 16'd10, 8'd0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty();

    // Back-to-back: start held high through FIN, so each next operation is
    // accepted on the FIN edge and done pulses are N_W+1 periods apart.
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      ry = N_W'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 20) == 0) ? '0 : D_W'($urandom_range(1, 255));
      if (rb == '0) drive(ry, rb, '1, '0, 1'b1);
      else          drive(ry, rb, ry / N_W'(rb), D_W'(ry % N_W'(rb)), 1'b0);
      wait_done();
    end
    start = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
